ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage RISC-V pipeline, directly downstream of the forwarding unit. It consumes the forwarding selects and ID/EX operands, resolves operands from its own EX/MEM result or MEM/WB write-back data, and executes single-cycle ALU ops or a multi-cycle iterative MUL. Results go into the EX/MEM pipeline register, which is owned by this block. While a MUL is in progress it stalls the upstream stages.

## Interface
- XLEN, 32, datapath width; MUL takes XLEN iteration cycles.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- valid_i  in  1  ID/EX holds a real instruction; 0 means bubble.
- rs1_data_i, rs2_data_i  in  XLEN  register-file operands from ID/EX.
- imm_i  in  XLEN  sign-extended immediate.
- alu_src_i  in  1  1 selects imm_i as operand B.
- alu_ctrl_i  in  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRA=6, MUL=7; other values produce 0.
- rd_addr_i  in  5  destination register.
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  in  1  control bits passed through to EX/MEM.
- forward_a_i, forward_b_i  in  2  forwarding selects: 00 = ID/EX, 10 = EX/MEM result, 01 = wb_data_i, 11 = treated as 00.
- wb_data_i  in  XLEN  MEM/WB write-back data.
- stall_o  out  1  hold PC, IF/ID and ID/EX (combinational).
- alu_result_o  out  XLEN  EX/MEM result; also the EX/MEM forwarding source.
- store_data_o  out  XLEN  EX/MEM forwarded rs2 value.
- rd_addr_o  out  5  EX/MEM destination register.
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  out  1  EX/MEM control bits.

## Operation
- Forwarded A = mux(forward_a_i) over {rs1_data_i, alu_result_o, wb_data_i}. Forwarded B is formed the same way from rs2_data_i.
- Store data = forwarded B, taken before the alu_src_i mux. Operand B = alu_src_i ? imm_i : forwarded B.
- Shifts use opB[4:0]. ADD/SUB wrap modulo 2^XLEN. MUL returns the low XLEN bits of the product.
- FSM states: IDLE, BUSY, DONE.
  - **IDLE**
    - Non-MUL or bubble: the EX/MEM register loads the result and controls every cycle. If valid_i=0, all EX/MEM control bits load 0.
    - valid_i=1 with MUL: stall_o=1. Latch forwarded A (multiplicand) and B (multiplier), clear the accumulator, set count=0, go to BUSY. EX/MEM loads a bubble (all control 0).
  - **BUSY**
    - stall_o=1.
    - Each cycle performs one shift-add step: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, count++.
    - EX/MEM loads a bubble.
    - When count==XLEN-1, go to DONE.
  - **DONE**
    - stall_o=0.
    - EX/MEM loads acc, plus rd/control from ID/EX (still held) and store data. The stage then returns to IDLE.
    - ID/EX inputs are not decoded as a new MUL in DONE, so the MUL is not re-issued.
- MUL operands are captured at issue. EX/MEM and MEM/WB drain during BUSY, and later changes on the forwarding sources are ignored.

## Timing
- Reset: all outputs 0, FSM IDLE, count/acc/operand latches 0. Reset mid-MUL aborts the MUL and no result is written.
- ALU ops: one cycle; result in EX/MEM at the edge after presentation.
- MUL presented in cycle T:
  - stall_o=1 in cycles T..T+XLEN, i.e. XLEN+1 cycles.
  - DONE is cycle T+XLEN+1.
  - The result is visible on alu_result_o after the edge ending T+XLEN+1.
- stall_o depends combinationally on state, valid_i and alu_ctrl_i. It has no path from the forward selects.
- A MUL immediately followed by a dependent op: the forwarding unit sees EX/MEM rd = MUL rd after DONE and selects 10; the dependent op uses the correct product.

## Structure
- Shared package: alu_ctrl encodings, forward-select encodings (FWD_IDEX=00, FWD_EXMEM=10, FWD_WB=01), FSM state enum, XLEN default.
- Sub-module iter_mul: the shift-add multiplier datapath (operand latches, accumulator, counter) with start/done signals. The FSM and the EX/MEM register stay in ex_stage.

## Test plan
- ADD x3 with rs1_data_i=5, EX/MEM result=20, forward_a_i=10, rs2_data_i=7, forward_b_i=00 -> alu_result_o=27 next cycle.
- SUB with forward_b_i=01, wb_data_i=9, rs1=30 -> 21. Same with forward_b_i=11 and rs2=4 -> 26.
- Store, mem_write_i=1, alu_src_i=1, imm=8, rs1=100, forward_b_i=01, wb_data_i=0xAB -> alu_result_o=108, store_data_o=0xAB, mem_write_o=1.
- MUL 7*6, XLEN=32 -> stall_o high exactly 33 cycles, bubbles in EX/MEM meanwhile, then alu_result_o=42 with reg_write_o=1. Repeat with 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- MUL then dependent ADD via forward_a_i=10, imm=1 -> ADD result 43 one cycle after the product appears. The MUL is not re-issued.
- rst_i asserted at BUSY count 10 -> outputs 0 immediately, stall_o=0. After release, an ADD executes normally.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage: ALU opcodes, forwarding selects,
// FSM states and the operand forwarding mux.
package ex_stage_pkg;

  localparam int unsigned Xlen   = 32;
  localparam int unsigned ShamtW = $clog2(Xlen);

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluXor = 4'd4,
    AluSll = 4'd5,
    AluSra = 4'd6,
    AluMul = 4'd7
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FwdIdex  = 2'b00,
    FwdWb    = 2'b01,
    FwdExmem = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } ex_state_e;

  // Select 11 falls back to the ID/EX operand.
  function automatic logic [Xlen-1:0] fwd_mux(logic [1:0] sel, logic [Xlen-1:0] idex,
                                              logic [Xlen-1:0] exmem, logic [Xlen-1:0] wb);
    case (sel)
      FwdExmem: return exmem;
      FwdWb:    return wb;
      default:  return idex;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding controls and EX/MEM outputs of the execute stage.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic            valid_i;
  logic [Xlen-1:0] rs1_data_i;
  logic [Xlen-1:0] rs2_data_i;
  logic [Xlen-1:0] imm_i;
  logic            alu_src_i;
  logic [3:0]      alu_ctrl_i;
  logic [4:0]      rd_addr_i;
  logic            reg_write_i;
  logic            mem_read_i;
  logic            mem_write_i;
  logic            mem_to_reg_i;
  logic [1:0]      forward_a_i;
  logic [1:0]      forward_b_i;
  logic [Xlen-1:0] wb_data_i;

  logic            stall_o;
  logic [Xlen-1:0] alu_result_o;
  logic [Xlen-1:0] store_data_o;
  logic [4:0]      rd_addr_o;
  logic            reg_write_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            mem_to_reg_o;

  modport master (
    output valid_i, rs1_data_i, rs2_data_i, imm_i, alu_src_i, alu_ctrl_i, rd_addr_i,
           reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, forward_a_i, forward_b_i,
           wb_data_i,
    input  stall_o, alu_result_o, store_data_o, rd_addr_o, reg_write_o, mem_read_o,
           mem_write_o, mem_to_reg_o
  );

  modport slave (
    input  valid_i, rs1_data_i, rs2_data_i, imm_i, alu_src_i, alu_ctrl_i, rd_addr_i,
           reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, forward_a_i, forward_b_i,
           wb_data_i,
    output stall_o, alu_result_o, store_data_o, rd_addr_o, reg_write_o, mem_read_o,
           mem_write_o, mem_to_reg_o
  );

endinterface

// File: rtl/ex_stage_iter_mul.sv
// Iterative shift-add multiplier: one partial-product step per cycle, Xlen steps per product.
module ex_stage_iter_mul
  import ex_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [Xlen-1:0] mcand_i,
  input  logic [Xlen-1:0] mplier_i,
  output logic [Xlen-1:0] acc_o,
  output logic            last_o
);

  localparam int unsigned CntW = $clog2(Xlen);

  logic [Xlen-1:0] mcand_q;
  logic [Xlen-1:0] mplier_q;
  logic [Xlen-1:0] acc_q;
  logic [CntW-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (start_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 1'b1;
    end
  end

  assign acc_o  = acc_q;
  // High during the final step, so the accumulator is complete on the following cycle.
  assign last_o = (count_q == CntW'(Xlen - 1));

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL with upstream stall,
// and the EX/MEM pipeline register.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  ex_stage_if.slave ex_if
);

  ex_state_e       state_q, state_d;
  logic [Xlen-1:0] op_a, fwd_b, op_b, alu_res;
  logic            is_mul, mul_start, mul_step, mul_last, stall;
  logic [Xlen-1:0] mul_acc;

  logic [Xlen-1:0] result_d, result_q;
  logic [Xlen-1:0] store_d, store_q;
  logic [4:0]      rd_d, rd_q;
  logic [3:0]      ctl_d, ctl_q;
  logic [3:0]      ctl_in;

  assign op_a   = fwd_mux(ex_if.forward_a_i, ex_if.rs1_data_i, result_q, ex_if.wb_data_i);
  assign fwd_b  = fwd_mux(ex_if.forward_b_i, ex_if.rs2_data_i, result_q, ex_if.wb_data_i);
  assign op_b   = ex_if.alu_src_i ? ex_if.imm_i : fwd_b;
  assign is_mul = (ex_if.alu_ctrl_i == AluMul);
  assign ctl_in = {ex_if.reg_write_i, ex_if.mem_read_i, ex_if.mem_write_i, ex_if.mem_to_reg_i};

  always_comb begin
    alu_res = '0;
    case (ex_if.alu_ctrl_i)
      AluAdd:  alu_res = op_a + op_b;
      AluSub:  alu_res = op_a - op_b;
      AluAnd:  alu_res = op_a & op_b;
      AluOr:   alu_res = op_a | op_b;
      AluXor:  alu_res = op_a ^ op_b;
      AluSll:  alu_res = op_a << op_b[ShamtW-1:0];
      AluSra:  alu_res = $signed(op_a) >>> op_b[ShamtW-1:0];
      default: alu_res = '0;
    endcase
  end

  ex_stage_iter_mul u_iter_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mul_start),
    .step_i   (mul_step),
    .mcand_i  (op_a),
    .mplier_i (fwd_b),
    .acc_o    (mul_acc),
    .last_o   (mul_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ex_if.valid_i && is_mul) state_d = StBusy;
      StBusy:  if (mul_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    result_d  = alu_res;
    store_d   = fwd_b;
    rd_d      = ex_if.rd_addr_i;
    ctl_d     = ex_if.valid_i ? ctl_in : 4'b0;
    unique case (state_q)
      StIdle: begin
        if (ex_if.valid_i && is_mul) begin
          stall     = 1'b1;
          mul_start = 1'b1;
          result_d  = '0;
          store_d   = '0;
          rd_d      = '0;
          ctl_d     = 4'b0;
        end
      end
      StBusy: begin
        stall    = 1'b1;
        mul_step = 1'b1;
        result_d = '0;
        store_d  = '0;
        rd_d     = '0;
        ctl_d    = 4'b0;
      end
      // ID/EX is still holding the MUL, so its rd and controls retire with the product.
      StDone: begin
        result_d = mul_acc;
        ctl_d    = ctl_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q <= '0;
      store_q  <= '0;
      rd_q     <= '0;
      ctl_q    <= '0;
    end else begin
      result_q <= result_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      ctl_q    <= ctl_d;
    end
  end

  assign ex_if.stall_o      = stall;
  assign ex_if.alu_result_o = result_q;
  assign ex_if.store_data_o = store_q;
  assign ex_if.rd_addr_o    = rd_q;
  assign ex_if.reg_write_o  = ctl_q[3];
  assign ex_if.mem_read_o   = ctl_q[2];
  assign ex_if.mem_write_o  = ctl_q[1];
  assign ex_if.mem_to_reg_o = ctl_q[0];

endmodule
